// File: rtl/uart_tx.sv
// UART transmitter: serialises bytes from a valid/ready source onto uart_txd,
// with a one-entry holding buffer and active-low CTS flow control at frame boundaries.
module uart_tx #(
  parameter int unsigned BIT_RATE     = 9600,
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    uart_txd,
  input  logic                    uart_cts,
  input  logic                    uart_tx_valid,
  output logic                    uart_tx_ready,
  input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
  output logic                    uart_tx_busy
);

  localparam int unsigned BIT_NS         = 1_000_000_000 / BIT_RATE;
  localparam int unsigned CLK_NS         = 1_000_000_000 / CLK_HZ;
  localparam int unsigned CYCLES_PER_BIT = BIT_NS / CLK_NS;
  localparam int unsigned CNT_W          = $clog2(CYCLES_PER_BIT);
  localparam int unsigned IDX_W          = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(PAYLOAD_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                  state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic [IDX_W-1:0]        idx, idx_n;
  logic                    stop_idx, stop_idx_n;
  logic [PAYLOAD_BITS-1:0] shift, shift_n, shift_dn;
  logic [PAYLOAD_BITS-1:0] buf_data, buf_data_n;
  logic                    buf_full, buf_full_n;
  logic                    txd_n, ready_n, busy_n;
  logic                    cts_meta, cts_s;
  logic                    bit_done, accept, take;

  // Two-flop synchroniser for the asynchronous far-end CTS; idles deasserted.
  always_ff @(posedge clk) begin
    if (reset) begin
      cts_meta <= 1'b1;
      cts_s    <= 1'b1;
    end else begin
      cts_meta <= uart_cts;
      cts_s    <= cts_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt           <= '0;
      idx           <= '0;
      stop_idx      <= 1'b0;
      shift         <= '0;
      buf_data      <= '0;
      buf_full      <= 1'b0;
      uart_txd      <= 1'b1;
      uart_tx_ready <= 1'b1;
      uart_tx_busy  <= 1'b0;
    end else begin
      cnt           <= cnt_n;
      idx           <= idx_n;
      stop_idx      <= stop_idx_n;
      shift         <= shift_n;
      buf_data      <= buf_data_n;
      buf_full      <= buf_full_n;
      uart_txd      <= txd_n;
      uart_tx_ready <= ready_n;
      uart_tx_busy  <= busy_n;
    end
  end

  assign bit_done = (cnt == CNT_LAST);
  assign shift_dn = shift >> 1;
  assign accept   = uart_tx_valid && uart_tx_ready;

  always_comb begin
    state_n    = state;
    cnt_n      = bit_done ? '0 : cnt + 1'b1;
    idx_n      = idx;
    stop_idx_n = stop_idx;
    shift_n    = shift;
    txd_n      = uart_txd;
    take       = 1'b0;

    case (state)
      IDLE: begin
        cnt_n = '0;
        txd_n = 1'b1;
        if (buf_full && !cts_s) begin
          take = 1'b1;
        end
      end
      START: begin
        if (bit_done) begin
          state_n = DATA;
          txd_n   = shift[0];
          idx_n   = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (idx == IDX_LAST) begin
            state_n    = STOP;
            txd_n      = 1'b1;
            stop_idx_n = 1'b0;
          end else begin
            shift_n = shift_dn;
            txd_n   = shift_dn[0];
            idx_n   = idx + 1'b1;
          end
        end
      end
      STOP: begin
        txd_n = 1'b1;
        if (bit_done) begin
          if (stop_idx == STOP_LAST) begin
            // Frame boundary: chain straight into the next frame when allowed.
            if (buf_full && !cts_s) begin
              take = 1'b1;
            end else begin
              state_n = IDLE;
            end
          end else begin
            stop_idx_n = stop_idx + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        txd_n   = 1'b1;
      end
    endcase

    if (take) begin
      state_n = START;
      shift_n = buf_data;
      txd_n   = 1'b0;
      cnt_n   = '0;
    end

    // A new accept on the same edge as a take leaves the buffer full.
    buf_full_n = accept || (buf_full && !take);
    buf_data_n = accept ? uart_tx_data : buf_data;
    ready_n    = !buf_full_n;
    busy_n     = (state_n != IDLE) || buf_full_n;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected bytes, per-DUT line monitors
// decode frames cycle-by-cycle and compare; the main process checks timing/handshake.
module tb_uart_tx;

  localparam int unsigned CPB = 10;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       cts1, valid1, txd1, ready1, busy1;
  logic       cts2, valid2, txd2, ready2, busy2;
  logic [7:0] data1, data2;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic [7:0]  exp1[$];
  logic [7:0]  exp2[$];
  int unsigned starts1[$];
  int unsigned starts2[$];

  uart_tx #(.BIT_RATE(5_000_000), .CLK_HZ(50_000_000), .PAYLOAD_BITS(8), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset(reset), .uart_txd(txd1), .uart_cts(cts1),
    .uart_tx_valid(valid1), .uart_tx_ready(ready1), .uart_tx_data(data1), .uart_tx_busy(busy1)
  );

  uart_tx #(.BIT_RATE(5_000_000), .CLK_HZ(50_000_000), .PAYLOAD_BITS(8), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .uart_txd(txd2), .uart_cts(cts2),
    .uart_tx_valid(valid2), .uart_tx_ready(ready2), .uart_tx_data(data2), .uart_tx_busy(busy2)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic txd_of(input int sel);
    return (sel != 0) ? txd2 : txd1;
  endfunction

  function automatic logic rdy_of(input int sel);
    return (sel != 0) ? ready2 : ready1;
  endfunction

  // Line monitor: detects a start bit, samples every cycle of the frame, then scores it.
  task automatic mon(input int sel, input int sb);
    forever begin
      @(negedge clk);
      if (txd_of(sel) === 1'b0 && !reset) begin
        int unsigned st;
        logic [7:0]  rx;
        logic [7:0]  e;
        bit          bad;
        bit          aborted;
        logic        lvl0;
        st = cyc; rx = '0; e = '0; bad = 1'b0; aborted = 1'b0; lvl0 = 1'b0;
        if (sel != 0) starts2.push_back(st); else starts1.push_back(st);
        for (int b = 0; b < 9 + sb; b++) begin
          for (int c = 0; c < int'(CPB); c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (reset) aborted = 1'b1;
            if (c == 0) begin
              lvl0 = txd_of(sel);
              if (b == 0 && lvl0 !== 1'b0) bad = 1'b1;
              else if (b >= 9 && lvl0 !== 1'b1) bad = 1'b1;
              else if (b >= 1 && b <= 8) rx[b-1] = lvl0;
            end else if (txd_of(sel) !== lvl0) begin
              bad = 1'b1;
            end
          end
        end
        if (aborted) begin
          if (sel != 0) exp2.delete(); else exp1.delete();
        end else if ((sel != 0 ? exp2.size() : exp1.size()) == 0) begin
          check("frame_unexpected", 32'(rx), 32'hFFFF_FFFF);
        end else begin
          e = (sel != 0) ? exp2.pop_front() : exp1.pop_front();
          check(sel != 0 ? "frame_data_sb2" : "frame_data", 32'(rx), 32'(e));
          check(sel != 0 ? "frame_timing_sb2" : "frame_timing", 32'(bad), 32'd0);
        end
      end
    end
  endtask

  initial mon(0, 1);
  initial mon(1, 2);

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(input int unsigned t);
    int n;
    n = 0;
    while (cyc < t && n < 10000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic send(input int sel, input logic [7:0] b, output int unsigned acc);
    int n;
    n = 0;
    @(negedge clk);
    if (sel != 0) begin valid2 = 1'b1; data2 = b; end
    else          begin valid1 = 1'b1; data1 = b; end
    while (!rdy_of(sel) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!rdy_of(sel)) check("send_timeout", 32'd0, 32'd1);
    else if (sel != 0) exp2.push_back(b);
    else exp1.push_back(b);
    @(negedge clk);
    acc = cyc;
    if (sel != 0) begin valid2 = 1'b0; data2 = ~b; end
    else          begin valid1 = 1'b0; data1 = ~b; end
  endtask

  task automatic wait_starts(input int sel, input int n, output int unsigned st);
    int k;
    k = 0;
    while ((sel != 0 ? starts2.size() : starts1.size()) < n && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if ((sel != 0 ? starts2.size() : starts1.size()) < n) begin
      check("start_timeout", 32'd0, 32'd1);
      st = cyc;
    end else begin
      st = (sel != 0) ? starts2[n-1] : starts1[n-1];
    end
  endtask

  task automatic hold_high(input int sel, input int n, input string name);
    bit bad;
    bad = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (txd_of(sel) !== 1'b1) bad = 1'b1;
    end
    check(name, 32'(bad), 32'd0);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation did not complete (cyc %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned acc, acc2, st, s2, c;
    int          base;
    cts1 = 1'b0; cts2 = 1'b0; valid1 = 1'b0; valid2 = 1'b0; data1 = '0; data2 = '0;

    // Reset values
    tick(3);
    check("rst_txd", 32'(txd1), 32'd1);
    check("rst_ready", 32'(ready1), 32'd1);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_txd_sb2", 32'(txd2), 32'd1);
    check("rst_busy_sb2", 32'(busy2), 32'd0);
    reset = 1'b0;
    tick(5);

    // Single byte 0xA5
    send(0, 8'hA5, acc);
    check("ready_after_accept", 32'(ready1), 32'd0);
    check("busy_after_accept", 32'(busy1), 32'd1);
    tick(1);
    check("ready_on_take", 32'(ready1), 32'd1);
    wait_starts(0, 1, st);
    check("latency", st - acc, 32'd1);
    wait_cyc(st + 99);
    check("busy_in_stop", 32'(busy1), 32'd1);
    tick(1);
    check("busy_clear", 32'(busy1), 32'd0);
    tick(5);

    // Back-to-back 0x00 then 0xFF
    base = starts1.size();
    send(0, 8'h00, acc);
    wait_cyc(acc + 30);
    send(0, 8'hFF, acc2);
    check("ready_full", 32'(ready1), 32'd0);
    wait_starts(0, base + 1, st);
    wait_cyc(st + 99);
    check("ready_held", 32'(ready1), 32'd0);
    tick(1);
    check("ready_second_take", 32'(ready1), 32'd1);
    wait_starts(0, base + 2, s2);
    check("b2b_gap", s2 - st, 32'd100);
    wait_cyc(s2 + 99);
    check("b2b_busy", 32'(busy1), 32'd1);
    tick(1);
    check("b2b_total", 32'(busy1), 32'd0);
    tick(5);

    // Flow control hold then release
    cts1 = 1'b1;
    tick(4);
    base = starts1.size();
    send(0, 8'h55, acc);
    check("cts_ready", 32'(ready1), 32'd0);
    check("cts_busy", 32'(busy1), 32'd1);
    hold_high(0, 300, "cts_hold");
    check("cts_still_buffered", 32'(ready1), 32'd0);
    cts1 = 1'b0;
    c = cyc;
    wait_starts(0, base + 1, st);
    check("cts_release", st - c, 32'd3);
    wait_cyc(st + 101);
    tick(5);

    // CTS rises mid-frame
    base = starts1.size();
    send(0, 8'h3C, acc);
    wait_starts(0, base + 1, st);
    wait_cyc(st + 30);
    cts1 = 1'b1;
    send(0, 8'hC3, acc2);
    wait_cyc(st + 100);
    hold_high(0, 200, "cts_midframe_hold");
    check("cts_mid_busy", 32'(busy1), 32'd1);
    check("cts_mid_ready", 32'(ready1), 32'd0);
    cts1 = 1'b0;
    c = cyc;
    wait_starts(0, base + 2, s2);
    check("cts_resume", s2 - c, 32'd3);
    wait_cyc(s2 + 101);
    tick(5);

    // Reset mid-frame with a byte buffered
    base = starts1.size();
    send(0, 8'h96, acc);
    wait_starts(0, base + 1, st);
    send(0, 8'h69, acc2);
    wait_cyc(st + 44);
    reset = 1'b1;
    tick(1);
    check("rst_mid_txd", 32'(txd1), 32'd1);
    check("rst_mid_ready", 32'(ready1), 32'd1);
    check("rst_mid_busy", 32'(busy1), 32'd0);
    tick(1);
    reset = 1'b0;
    hold_high(0, 200, "rst_quiet");
    check("rst_no_frame", 32'(starts1.size()), 32'(base + 1));
    check("rst_idle_busy", 32'(busy1), 32'd0);
    tick(5);

    // Two stop bits, 0x81
    send(1, 8'h81, acc);
    wait_starts(1, 1, st);
    check("latency_sb2", st - acc, 32'd1);
    wait_cyc(st + 109);
    check("sb2_busy", 32'(busy2), 32'd1);
    tick(1);
    check("sb2_frame_len", 32'(busy2), 32'd0);
    tick(20);

    check("drained", 32'(exp1.size()), 32'd0);
    check("drained_sb2", 32'(exp2.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter; the transmit-side companion of the existing UART receiver, with matching framing and parameters.
- Serialises bytes from a valid/ready source onto uart_txd as 8N1 by default: start bit, PAYLOAD_BITS data bits LSB first, STOP_BITS stop bits.
- Has a one-entry holding buffer, so the next byte can be queued while the current frame shifts out.
- Honours active-low hardware flow control (uart_cts) from the far end, checked at frame boundaries only.

Parameters:
- BIT_RATE, 9600, line bit rate in bits/s.
- CLK_HZ, 50_000_000, clk frequency in Hz.
- PAYLOAD_BITS, 8, data bits per frame (1..8).
- STOP_BITS, 1, stop bits per frame (1..2).
- Derived localparam CYCLES_PER_BIT = (1_000_000_000/BIT_RATE) / (1_000_000_000/CLK_HZ), integer division at each step. Must be >= 2.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous reset, active-high.
- uart_txd, output, 1, UART transmit pin; idle high.
- uart_cts, input, 1, clear-to-send, active low; asynchronous, external.
- uart_tx_valid, input, 1, source presents a byte on uart_tx_data.
- uart_tx_ready, output, 1, holding buffer empty; byte accepted when valid&&ready at a clk edge.
- uart_tx_data, input, PAYLOAD_BITS, byte to send.
- uart_tx_busy, output, 1, high while a frame is in flight or a byte is buffered.

Behaviour:
- Reset (synchronous, reset=1 at posedge clk):
  - uart_txd=1, uart_tx_ready=1, uart_tx_busy=0.
  - FSM=IDLE; counters cleared; buffer empty.
  - CTS synchroniser flops set to 1 (deasserted).
  - Reset mid-frame: at the reset edge the frame aborts, txd returns high, and any buffered byte is discarded.
- CTS: two-flop synchroniser; cts_s is the synchronised value. Sampled only in IDLE and at end of the last stop bit. Deassertion mid-frame never truncates a frame.
- Holding buffer:
  - uart_tx_ready = !buf_full (registered).
  - Accept sets buf_full; the FSM taking the byte into the shift register clears it.
  - Accept and take on the same edge: buffer stays full with the new byte.
  - uart_tx_data is ignored when valid=0 or ready=0.
- Bit timing: each bit lasts exactly CYCLES_PER_BIT clocks. Cycle counter runs 0..CYCLES_PER_BIT-1, wraps, and asserts bit_done at CYCLES_PER_BIT-1.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: txd=1. If buf_full && cts_s==0, go to START at the next edge: load shift register, clear buf_full, drive txd=0 (registered), counter=0.
  - START: on bit_done go to DATA, txd=shift[0], bit index=0.
  - DATA: on bit_done, shift right and index++. txd shows the next bit. After bit PAYLOAD_BITS-1 completes, go to STOP with txd=1.
  - STOP: lasts STOP_BITS*CYCLES_PER_BIT clocks. At the end:
    - if buf_full && cts_s==0, go directly to START (back-to-back, no idle gap);
    - else go to IDLE.
- Latency: with cts_s already low and the FSM in IDLE, a byte accepted at edge N drives txd low from edge N+1.
- Frame length: (1+PAYLOAD_BITS+STOP_BITS)*CYCLES_PER_BIT clocks.
- uart_tx_busy = (FSM != IDLE) || buf_full, registered consistently with the FSM. It is 0 only when the line is idle and nothing is queued.
- uart_txd is driven from a flop only; no combinational path from inputs.

Test Plan:
All scenarios use CLK_HZ=50_000_000 and BIT_RATE=5_000_000, so CYCLES_PER_BIT=10, with uart_cts=0 unless stated.
- Single byte 0xA5: txd low 10 clks, then bits 1,0,1,0,0,1,0,1 at 10 clks each, then high 10 clks. Frame is 100 clks. txd falls 1 clk after accept. busy clears at frame end.
- Back-to-back 0x00 then 0xFF, second offered during the first frame: ready deasserts after the first accept and reasserts when the first byte starts shifting. Second start bit immediately follows the first stop bit. Total 200 clks with no idle gap.
- Flow control: hold cts=1 and offer 0x55. Byte is buffered (ready=0, busy=1) and txd stays 1 indefinitely. Drop cts: txd falls 3 clks later (2 sync + 1).
- CTS rises mid-frame during 0x3C: frame completes intact; a queued second byte is held until cts returns low.
- Reset at clk 45 of a frame with a byte buffered: next cycle txd=1, ready=1, busy=0; no further edges on txd.
- STOP_BITS=2, byte 0x81: stop period is 20 clks high; frame is 110 clks.
